// File: rtl/main_memory_ctrl.sv
// Backing-store model behind the cache controller: accepts one strobed
// read or write, waits WAIT_CYCLES clocks, then pulses MReady with read data.
module main_memory_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [7:0]  CNT_LOAD = 8'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                do_write;

  // The access completes on the edge that leaves ACCESS with the counter at 0.
  assign do_write = (state_q == ACCESS) && (cnt_q == 8'd0) && rw_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (MStrobe) begin
          rw_d    = MRW;
          addr_d  = MAddr;
          wdata_d = MDataIn;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // A strobe arriving mid-access is discarded, only flagged.
        if (MStrobe) err_d = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = 8'(cnt_q - 8'd1);
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
          if (!rw_q) rdata_d = mem[addr_q];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCESS);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset; a reset mid-access still blocks the
  // write because state_q is forced to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (do_write) mem[addr_q] <= wdata_q;
  end

  assign MDataOut = rdata_q;
  assign MReady   = ready_q;
  assign Busy     = busy_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: a WAIT_CYCLES=4 instance for the main
// scenarios and a WAIT_CYCLES=1 instance for minimum latency.
module tb_main_memory_ctrl;

  localparam int W0 = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        m_strobe = 1'b0, m_rw = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_din = '0, m_dout;
  logic        m_ready, m_busy, m_err;

  logic        s_strobe = 1'b0, s_rw = 1'b0;
  logic [7:0]  s_addr = '0;
  logic [31:0] s_din = '0, s_dout;
  logic        s_ready, s_busy, s_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_ready_cyc = 0;

  main_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W0)) dut (
    .clk(clk), .reset(reset), .MStrobe(m_strobe), .MRW(m_rw), .MAddr(m_addr),
    .MDataIn(m_din), .MDataOut(m_dout), .MReady(m_ready), .Busy(m_busy), .Err(m_err)
  );

  main_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .MStrobe(s_strobe), .MRW(s_rw), .MAddr(s_addr),
    .MDataIn(s_din), .MDataOut(s_dout), .MReady(s_ready), .Busy(s_busy), .Err(s_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a request so that it is sampled at the next rising edge (E0).
  task automatic start_req(input logic rw, input logic [7:0] addr, input logic [31:0] data);
    m_strobe = 1'b1;
    m_rw     = rw;
    m_addr   = addr;
    m_din    = data;
  endtask

  // Follows one access from E0 to its DONE cycle (sample k = cycle after E_k).
  task automatic run_access(input string name, input logic rw, input logic [31:0] exp_rd,
                            input int drop_at, input bit scramble);
    int busy_n, ready_n, ready_k, both_n;
    logic [31:0] rd;
    busy_n = 0; ready_n = 0; ready_k = -1; both_n = 0; rd = 'x;
    for (int k = 0; k <= W0; k++) begin
      @(negedge clk);
      if (m_busy) busy_n++;
      if (m_ready && m_busy) both_n++;
      if (m_ready) begin
        ready_n++;
        ready_k = k;
        rd = m_dout;
        last_ready_cyc = cyc;
      end
      m_strobe = (k == drop_at);
      if (k == drop_at) begin
        m_rw   = 1'b1;
        m_din  = 32'h5A5A_5A5A;
      end
      if (scramble && k < W0) begin
        m_addr = 8'h41;
        m_din  = 32'hFFFF_0000 | 32'(k);
      end
    end
    total++;
    if (ready_k !== W0 || ready_n !== 1) begin
      bad++;
      $display("FAIL %s ready_timing: got k=%0d count=%0d, want k=%0d count=1", name, ready_k, ready_n, W0);
    end
    total++;
    if (busy_n !== W0 || both_n !== 0) begin
      bad++;
      $display("FAIL %s busy: got %0d cycles (overlap %0d), want %0d (overlap 0)", name, busy_n, both_n, W0);
    end
    if (!rw) begin
      total++;
      if (rd !== exp_rd) begin
        bad++;
        $display("FAIL %s rdata: got %h, want %h", name, rd, exp_rd);
      end
    end
  endtask

  task automatic access(input string name, input logic rw, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd);
    @(negedge clk);
    start_req(rw, addr, data);
    run_access(name, rw, exp_rd, -1, 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({m_ready, m_busy, m_err, s_ready, s_busy, s_err} !== 6'b0 || m_dout !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b busy=%b err=%b dout=%h, want all 0", m_ready, m_busy, m_err, m_dout);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    access("wr_deadbeef", 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0);
    access("rd_deadbeef", 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_back_to_back();
    int t1;
    @(negedge clk);
    start_req(1'b1, 8'h01, 32'h1111_1111);
    run_access("b2b_wr", 1'b1, 32'h0, -1, 1'b0);
    t1 = last_ready_cyc;
    start_req(1'b0, 8'h01, 32'h0);
    run_access("b2b_rd", 1'b0, 32'h1111_1111, -1, 1'b0);
    total++;
    if (last_ready_cyc - t1 !== 5) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles, want 5", last_ready_cyc - t1);
    end
    total++;
    if (m_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_err: got %b, want 0", m_err);
    end
  endtask

  task automatic test_input_hold();
    access("hold_pre", 1'b1, 8'h41, 32'h0, 32'h0);
    @(negedge clk);
    start_req(1'b1, 8'h20, 32'h0BAD_F00D);
    run_access("hold_wr", 1'b1, 32'h0, -1, 1'b1);
    access("hold_rd_cap", 1'b0, 8'h20, 32'h0, 32'h0BAD_F00D);
    access("hold_rd_other", 1'b0, 8'h41, 32'h0, 32'h0);
  endtask

  task automatic test_dropped();
    access("drop_pre", 1'b1, 8'h02, 32'hA5A5_A5A5, 32'h0);
    @(negedge clk);
    start_req(1'b0, 8'h02, 32'h0);
    run_access("drop_rd", 1'b0, 32'hA5A5_A5A5, 1, 1'b0);
    total++;
    if (m_err !== 1'b1) begin
      bad++;
      $display("FAIL drop_err: got %b, want 1", m_err);
    end
    access("drop_rd_again", 1'b0, 8'h02, 32'h0, 32'hA5A5_A5A5);
    total++;
    if (m_err !== 1'b1) begin
      bad++;
      $display("FAIL drop_err_sticky: got %b, want 1", m_err);
    end
  endtask

  task automatic test_reset_mid();
    access("rst_pre", 1'b1, 8'h03, 32'h0, 32'h0);
    @(negedge clk);
    start_req(1'b1, 8'h03, 32'h1234_5678);
    @(negedge clk);
    m_strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({m_ready, m_busy, m_err} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_outputs: got ready=%b busy=%b err=%b, want 000", m_ready, m_busy, m_err);
    end
    repeat (W0 + 1) begin
      @(negedge clk);
      total++;
      if (m_ready !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_ready: got %b during reset, want 0", m_ready);
      end
    end
    reset = 1'b1;
    access("rst_rd", 1'b0, 8'h03, 32'h0, 32'h0);
  endtask

  task automatic access1(input string name, input logic rw, input logic [7:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd);
    @(negedge clk);
    s_strobe = 1'b1; s_rw = rw; s_addr = addr; s_din = data;
    @(negedge clk);
    s_strobe = 1'b0;
    total++;
    if (s_busy !== 1'b1 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s k0: got busy=%b ready=%b, want busy=1 ready=0", name, s_busy, s_ready);
    end
    @(negedge clk);
    total++;
    if (s_busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s k1: got busy=%b ready=%b, want busy=0 ready=1", name, s_busy, s_ready);
    end
    if (!rw) begin
      total++;
      if (s_dout !== exp_rd) begin
        bad++;
        $display("FAIL %s rdata: got %h, want %h", name, s_dout, exp_rd);
      end
    end
    @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s k2: got busy=%b ready=%b, want 0 0", name, s_busy, s_ready);
    end
  endtask

  task automatic test_wait1();
    access1("w1_wr", 1'b1, 8'h05, 32'hCAFE_F00D, 32'h0);
    access1("w1_rd", 1'b0, 8'h05, 32'h0, 32'hCAFE_F00D);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_input_hold();
    test_dropped();
    test_reset_mid();
    test_wait1();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
